// File: rtl/seg_scan_if.sv
// seg_scan_if: multiplexed 7-segment scan lines plus the reconstructed display seen by the monitor
interface seg_scan_if;
  logic sel1, sel2, sel3, sel4;
  logic [7:0] seg;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp, bad;
  logic frame_done, valid, overlap_err;
  modport master (
    output sel1, sel2, sel3, sel4, seg,
    input  digit0, digit1, digit2, digit3, dp, bad, frame_done, valid, overlap_err
  );
  modport slave (
    input  sel1, sel2, sel3, sel4, seg,
    output digit0, digit1, digit2, digit3, dp, bad, frame_done, valid, overlap_err
  );
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds four scanned 7-segment digits, publishes whole frames and flags scan faults
module seg_scan_capture #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 2_000_000
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} state_t;
  localparam logic [7:0]  SETTLE_W  = 8'(SETTLE);
  localparam logic [23:0] TIMEOUT_W = 24'(TIMEOUT);
  state_t state, state_nx;
  logic [3:0] r_sel, ref_sel, mask, sh_dp, sh_bad, val;
  logic [7:0] r_seg, ref_seg, cnt, cnt_nx;
  logic [3:0][3:0] sh_val;
  logic [23:0] tcnt, tcnt_nx;
  logic [1:0] idx;
  logic one_hot, multi_hot, same, hold, restart, cap, publish, vbad;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction
  always_comb begin
    one_hot   = (r_sel != 4'd0) && ((r_sel & (r_sel - 4'd1)) == 4'd0);
    multi_hot = (r_sel != 4'd0) && !one_hot;
    same      = (r_sel == ref_sel) && (r_seg == ref_seg);
    // a held, already captured pattern is never re-captured
    hold      = (state == CAPTURED) && same;
    restart   = (state == IDLE) || !same;
    cnt_nx    = restart ? 8'd1 : cnt + 8'd1;
    cap       = one_hot && !hold && (cnt_nx == SETTLE_W);
    state_nx  = !one_hot ? IDLE : (hold || cap) ? CAPTURED : SETTLING;
    idx       = {r_sel[3] | r_sel[2], r_sel[3] | r_sel[1]};
    {vbad, val} = decode(r_seg[6:0]);
    publish   = &mask;
    tcnt_nx   = publish ? 24'd0 : (&tcnt ? tcnt : tcnt + 24'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      r_sel           <= '0;
      r_seg           <= '0;
      ref_sel         <= '0;
      ref_seg         <= '0;
      cnt             <= '0;
      mask            <= '0;
      sh_val          <= '0;
      sh_dp           <= '0;
      sh_bad          <= '0;
      tcnt            <= '0;
      bus.digit0      <= '0;
      bus.digit1      <= '0;
      bus.digit2      <= '0;
      bus.digit3      <= '0;
      bus.dp          <= '0;
      bus.bad         <= '0;
      bus.frame_done  <= 1'b0;
      bus.valid       <= 1'b0;
      bus.overlap_err <= 1'b0;
    end else begin
      r_sel <= {bus.sel4, bus.sel3, bus.sel2, bus.sel1};
      r_seg <= bus.seg;
      state <= state_nx;
      if (one_hot && !hold) begin
        cnt     <= cnt_nx;
        ref_sel <= r_sel;
        ref_seg <= r_seg;
      end
      if (multi_hot) bus.overlap_err <= 1'b1;
      if (cap) begin
        sh_val[idx] <= val;
        sh_dp[idx]  <= r_seg[7];
        sh_bad[idx] <= vbad;
      end
      // a capture on the publish edge starts the next frame's mask
      mask <= (publish ? 4'd0 : mask) | (cap ? r_sel : 4'd0);
      bus.frame_done <= publish;
      tcnt <= tcnt_nx;
      if (publish) begin
        bus.digit0 <= sh_val[0];
        bus.digit1 <= sh_val[1];
        bus.digit2 <= sh_val[2];
        bus.digit3 <= sh_val[3];
        bus.dp     <= sh_dp;
        bus.bad    <= sh_bad;
        bus.valid  <= 1'b1;
      end else if (tcnt_nx >= TIMEOUT_W) begin
        bus.valid  <= 1'b0;
      end
    end
  end
endmodule
